// File: rtl/typed_frame_tx_if.sv
// ---------------------------------------------------------------------------
// typed_frame_tx_if
//
// Purpose: byte stream between the typed frame transmitter and its sink.
//
// Handshake: a byte transfers on every rising clock edge where valid && ready
// are both high. Once valid is raised, the source holds data and valid stable
// until that transfer happens. The sink may drive ready freely, and ready may
// depend on valid.
//
// Signals:
//   data   [7:0]  byte presented by the source
//   valid         data holds a byte that has not been taken yet
//   ready         sink can take the byte this cycle
//
// Modports:
//   master  source side (drives data/valid, samples ready)
//   slave   sink side   (samples data/valid, drives ready)
// ---------------------------------------------------------------------------
interface typed_frame_tx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/typed_frame_tx.sv
// ---------------------------------------------------------------------------
// typed_frame_tx
//
// Purpose: when start is accepted, takes a snapshot of a set of typed values.
// It then sends them as one frame on an 8-bit valid/ready stream:
//   HEADER, [SEQ], reg8, reg8_signed, reg32, reg32_signed, int, longint,
//   bits65 (9 bytes, top byte = {7'b0, bit64}), CSUM
// Each field goes out little-endian as its raw bit pattern. CSUM is the XOR of
// the 31 payload bytes. It does not include HEADER or SEQ.
//
// Optional feature: define TYPED_FRAME_TX_SEQNUM_EN to insert an 8-bit
// sequence byte after HEADER. The counter starts at 0 and advances on every
// done pulse. Without the macro the frame is 33 bytes and has no SEQ state.
//
// Parameters:
//   HEADER    first byte of every frame
//   IDLE_GAP  idle cycles after the CSUM transfer before start is accepted (0..15)
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   start            one-cycle request; honoured only in IDLE with no gap pending
//   in_*             value fields sampled on the accepting edge
//   tx               byte stream (master side): data, valid, ready
//   busy             frame in progress, from start accept to CSUM transfer
//   done             one-cycle pulse in the cycle after the CSUM transfer
//   dbg_state        current FSM state, for observation
// ---------------------------------------------------------------------------
module typed_frame_tx #(
  parameter logic [7:0]  HEADER   = 8'hA5,
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              in_reg8,
  input  logic [7:0]              in_reg8_signed,
  input  logic [31:0]             in_reg32,
  input  logic [31:0]             in_reg32_signed,
  input  logic [31:0]             in_int,
  input  logic [63:0]             in_longint,
  input  logic [64:0]             in_bits65,
  typed_frame_tx_if.master        tx,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              dbg_state
);

`ifdef TYPED_FRAME_TX_SEQNUM_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_SEQ     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CSUM    = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd3,
    S_CSUM    = 3'd4
  } state_t;
`endif

  localparam logic [4:0] LAST_IDX = 5'd30;
  localparam logic [3:0] GAP_LOAD = 4'(IDLE_GAP);

  state_t       state_q;
  state_t       state_d;
  logic [4:0]   idx_q;
  logic [247:0] payload_q;
  logic [7:0]   csum_q;
  logic [3:0]   gap_q;
  logic         done_q;
  logic [7:0]   data_c;
  logic [7:0]   pay_byte;
  logic         hs;
  logic         start_ok;

`ifdef TYPED_FRAME_TX_SEQNUM_EN
  logic [7:0]   seq_q;
`endif

  // Payload image, byte 0 in the low bits. Each field is stored LSB-first, so
  // walking the byte index gives the little-endian field order directly.
  assign pay_byte = payload_q[{idx_q, 3'b000} +: 8];

  assign hs       = tx.valid && tx.ready;
  assign start_ok = start && (state_q == S_IDLE) && (gap_q == 4'd0);

  assign tx.valid  = (state_q != S_IDLE);
  assign tx.data   = data_c;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

  // Next state and byte mux. data is 0 whenever nothing is offered.
  always_comb begin
    state_d = state_q;
    data_c  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_HDR;
      end
      S_HDR: begin
        data_c = HEADER;
        if (hs) begin
`ifdef TYPED_FRAME_TX_SEQNUM_EN
          state_d = S_SEQ;
`else
          state_d = S_PAYLOAD;
`endif
        end
      end
`ifdef TYPED_FRAME_TX_SEQNUM_EN
      S_SEQ: begin
        data_c = seq_q;
        if (hs) state_d = S_PAYLOAD;
      end
`endif
      S_PAYLOAD: begin
        data_c = pay_byte;
        if (hs && (idx_q == LAST_IDX)) state_d = S_CSUM;
      end
      S_CSUM: begin
        data_c = csum_q;
        if (hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 5'd0;
      payload_q <= '0;
      csum_q    <= 8'h00;
      gap_q     <= 4'd0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;

      if (start_ok) begin
        payload_q <= {7'b0, in_bits65, in_longint, in_int, in_reg32_signed,
                      in_reg32, in_reg8_signed, in_reg8};
        csum_q    <= 8'h00;
        idx_q     <= 5'd0;
      end

      // Index wraps to 0 as the last payload byte leaves, ready for the next frame.
      if ((state_q == S_PAYLOAD) && hs) begin
        csum_q <= csum_q ^ pay_byte;
        idx_q  <= (idx_q == LAST_IDX) ? 5'd0 : idx_q + 5'd1;
      end

      // The gap starts counting on the CSUM transfer, so with IDLE_GAP=0 a
      // start in the done cycle is already accepted.
      if ((state_q == S_CSUM) && hs) begin
        done_q <= 1'b1;
        gap_q  <= GAP_LOAD;
      end else if ((state_q == S_IDLE) && (gap_q != 4'd0)) begin
        gap_q <= gap_q - 4'd1;
      end
    end
  end

`ifdef TYPED_FRAME_TX_SEQNUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q <= 8'h00;
    end else if (done_q) begin
      seq_q <= seq_q + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_typed_frame_tx.sv
module tb_typed_frame_tx;

`ifdef TYPED_FRAME_TX_SEQNUM_EN
  localparam int FRAME_LEN = 34;
  localparam int HDR_BYTES = 2;
`else
  localparam int FRAME_LEN = 33;
  localparam int HDR_BYTES = 1;
`endif

  typedef struct {
    logic [7:0]  r8;
    logic [7:0]  r8s;
    logic [31:0] r32;
    logic [31:0] r32s;
    logic [31:0] i32;
    logic [63:0] l64;
    logic [64:0] b65;
    logic [7:0]  exp_csum;
    int          mode;        // 0 ready always, 1 ready toggles, 2 random ready
    int          exp_cycles;  // 0 = cycle count not checked
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        start_g = 1'b0;
  logic [7:0]  in_reg8 = '0;
  logic [7:0]  in_reg8_signed = '0;
  logic [31:0] in_reg32 = '0;
  logic [31:0] in_reg32_signed = '0;
  logic [31:0] in_int = '0;
  logic [63:0] in_longint = '0;
  logic [64:0] in_bits65 = '0;
  logic        busy, done, busy_g, done_g;
  logic [2:0]  dbg_state, dbg_state_g;

  typed_frame_tx_if tx();
  typed_frame_tx_if tx_g();

  typed_frame_tx u_dut (
    .clk(clk), .rst(rst), .start(start),
    .in_reg8(in_reg8), .in_reg8_signed(in_reg8_signed),
    .in_reg32(in_reg32), .in_reg32_signed(in_reg32_signed),
    .in_int(in_int), .in_longint(in_longint), .in_bits65(in_bits65),
    .tx(tx), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  typed_frame_tx #(.HEADER(8'hA5), .IDLE_GAP(3)) u_gap (
    .clk(clk), .rst(rst), .start(start_g),
    .in_reg8(in_reg8), .in_reg8_signed(in_reg8_signed),
    .in_reg32(in_reg32), .in_reg32_signed(in_reg32_signed),
    .in_int(in_int), .in_longint(in_longint), .in_bits65(in_bits65),
    .tx(tx_g), .busy(busy_g), .done(done_g), .dbg_state(dbg_state_g)
  );

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int frames_done = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] model_cs;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: the frame as a list of bytes built field by field.
  task automatic push_le(input logic [71:0] val, input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'(val >> (8 * i));
      exp_q.push_back(b);
      model_cs = model_cs ^ b;
    end
  endtask

  task automatic model_frame(input vec_t v, input logic [7:0] seq);
    exp_q.delete();
    model_cs = 8'h00;
    exp_q.push_back(8'hA5);
`ifdef TYPED_FRAME_TX_SEQNUM_EN
    exp_q.push_back(seq);
`else
    if (seq === 8'hxx) exp_q.push_back(8'hxx);
`endif
    push_le(72'(v.r8), 1);
    push_le(72'(v.r8s), 1);
    push_le(72'(v.r32), 4);
    push_le(72'(v.r32s), 4);
    push_le(72'(v.i32), 4);
    push_le(72'(v.l64), 8);
    push_le(72'(v.b65), 9);
    exp_q.push_back(model_cs);
  endtask

  // ---------------- driver tasks ----------------
  // Pulse start from a point #1 after an edge; returns #1 after the accepting
  // edge, with the inputs scrambled so late changes would show up as errors.
  task automatic launch(input vec_t v, input bit hold);
    in_reg8 = v.r8; in_reg8_signed = v.r8s;
    in_reg32 = v.r32; in_reg32_signed = v.r32s;
    in_int = v.i32; in_longint = v.l64; in_bits65 = v.b65;
    start = 1'b1;
    @(posedge clk); #1;
    start = hold;
    in_reg8 = 8'($urandom); in_reg8_signed = 8'($urandom);
    in_reg32 = $urandom; in_reg32_signed = $urandom; in_int = $urandom;
    in_longint = {$urandom, $urandom};
    in_bits65 = {1'($urandom_range(0, 1)), $urandom, $urandom};
  endtask

  // Collect one frame from the current cycle, checking that valid and busy
  // stay high and that the byte holds while stalled. Returns in the done cycle.
  task automatic collect(input int mode, output int cycles);
    logic [7:0] prev_data;
    bit prev_stall, r, steady;
    got_q.delete();
    cycles = 0; prev_stall = 0; prev_data = 8'h00; steady = 1;
    while (got_q.size() < FRAME_LEN && cycles < 400) begin
      case (mode)
        1:       r = (cycles % 2 == 0);
        2:       r = ($urandom_range(0, 3) != 0);
        default: r = 1'b1;
      endcase
      tx.ready = r;
      if (!tx.valid || !busy) steady = 0;
      if (prev_stall && tx.data !== prev_data) steady = 0;
      if (tx.valid && r) got_q.push_back(tx.data);
      prev_stall = tx.valid && !r;
      prev_data = tx.data;
      @(posedge clk); #1;
      cycles++;
    end
    tx.ready = 1'b1;
    check("valid_busy_hold", 72'(steady), 72'd1);
    check("done_cycle", 72'({done, tx.valid, busy}), 72'(3'b100));
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_len"}, 72'(got_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 72'(got_q[i]), 72'(exp_q[i]));
  endtask

  task automatic do_frame(input vec_t v, input bit hold, input string tag);
    int cyc;
    model_frame(v, 8'(frames_done));
    launch(v, hold);
    collect(v.mode, cyc);
    compare_frame(tag);
    if (v.exp_cycles > 0) check({tag, "_cycles"}, 72'(cyc), 72'(v.exp_cycles));
    frames_done++;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v.r8 = 8'($urandom); v.r8s = 8'($urandom);
    v.r32 = $urandom; v.r32s = $urandom; v.i32 = $urandom;
    v.l64 = {$urandom, $urandom};
    v.b65 = {1'($urandom_range(0, 1)), $urandom, $urandom};
    v.exp_csum = 8'h00; v.mode = 2; v.exp_cycles = 0;
    return v;
  endfunction

  // ---------------- test ----------------
  vec_t tbl[4];

  initial begin
    vec_t v;
    int n, idle;
    tx.ready = 1'b1;
    tx_g.ready = 1'b1;

    tbl[0] = '{8'h00, 8'h00, 32'h0, 32'h0, 32'h0, 64'h0, 65'h0, 8'h00, 0, FRAME_LEN};
    tbl[1] = '{8'h01, 8'hFF, 32'h0, 32'h0, 32'h0, 64'h0, 65'h0, 8'hFE, 0, FRAME_LEN};
    tbl[2] = '{8'h00, 8'h00, 32'h0, 32'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFE,
               65'h1_0000_0000_0000_0001, 8'h01, 0, FRAME_LEN};
    tbl[3] = '{8'h00, 8'h00, 32'hDEAD_BEEF, 32'h0, 32'h0, 64'h0, 65'h0, 8'h22, 1,
               2 * FRAME_LEN - 1};

    // Reset values while rst is held.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 72'(tx.valid), 72'd0);
    check("rst_data", 72'(tx.data), 72'd0);
    check("rst_busy", 72'(busy), 72'd0);
    check("rst_done", 72'(done), 72'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven frames.
    for (int i = 0; i < 4; i++) begin
      do_frame(tbl[i], 1'b0, $sformatf("tbl%0d", i));
      if (got_q.size() > 0) check($sformatf("tbl%0d_csum", i), 72'(got_q[$]), 72'(tbl[i].exp_csum));
      repeat (2) @(posedge clk);
      #1;
    end

    // start held high for a whole frame, dropped in the done cycle: one frame only.
    v = rand_vec(); v.mode = 0; v.exp_cycles = FRAME_LEN;
    do_frame(v, 1'b1, "hold");
    start = 1'b0;
    @(posedge clk); #1;
    check("hold_single_frame", 72'({tx.valid, busy}), 72'd0);

    // start in the done cycle with IDLE_GAP=0 launches the next frame at once.
    v = rand_vec(); v.mode = 0; v.exp_cycles = FRAME_LEN;
    do_frame(v, 1'b0, "b2b_a");
    v = rand_vec(); v.mode = 0; v.exp_cycles = FRAME_LEN;
    do_frame(v, 1'b0, "b2b_b");
    @(posedge clk); #1;

    // IDLE_GAP=3 instance: start held from the done cycle is ignored 3 idle cycles.
    start_g = 1'b1;
    @(posedge clk); #1;
    start_g = 1'b0;
    check("gap_hdr", 72'({tx_g.valid, tx_g.data}), 72'({1'b1, 8'hA5}));
    n = 0;
    while (!done_g && n < 200) begin @(posedge clk); #1; n++; end
    check("gap_done_seen", 72'(done_g), 72'd1);
    start_g = 1'b1; idle = 0; n = 0;
    while (!tx_g.valid && n < 20) begin
      @(posedge clk); #1; n++;
      if (!tx_g.valid) idle++;
    end
    start_g = 1'b0;
    check("gap_idle_cycles", 72'(idle), 72'd3);
    check("gap_second_hdr", 72'({tx_g.valid, tx_g.data}), 72'({1'b1, 8'hA5}));
    n = 0;
    while (!done_g && n < 200) begin @(posedge clk); #1; n++; end
    check("gap_second_done", 72'(done_g), 72'd1);

    // Reset at payload byte 10 aborts the frame.
    v = rand_vec(); v.mode = 0;
    model_frame(v, 8'(frames_done));
    launch(v, 1'b0);
    tx.ready = 1'b1;
    repeat (HDR_BYTES + 10) @(posedge clk);
    #1;
    check("abort_byte10", 72'(tx.data), 72'(exp_q[HDR_BYTES + 10]));
    #2 rst = 1'b1;
    #1;
    check("abort_outputs", 72'({tx.valid, busy, done, tx.data}), 72'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    frames_done = 0;
    @(posedge clk); #1;
    check("abort_no_resume", 72'({tx.valid, busy, done}), 72'd0);

    // Three back-to-back fresh frames (SEQ 0,1,2 when the sequence byte is on).
    for (int i = 0; i < 3; i++) begin
      v = rand_vec(); v.mode = 0; v.exp_cycles = FRAME_LEN;
      do_frame(v, 1'b0, $sformatf("fresh%0d", i));
    end

    // Randomized frames with random backpressure and random idle gaps.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      v = rand_vec();
      if (i == 0) begin v.b65 = {1'b1, 64'h0}; v.l64 = 64'h8000_0000_0000_0000; end
      do_frame(v, 1'b0, $sformatf("rnd%0d", i));
    end

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/typed_frame_tx.md
Name: typed_frame_tx

Overview:
- Frame transmitter. On a start pulse it captures a snapshot of typed values (8/32/64/65-bit, signed and unsigned) and sends them byte-wise on an 8-bit valid/ready stream.
- The receiving end consumes the same `data[7:0]` byte interface.
- Used by the testbench to check that multi-width and signed values survive transport in both directions.

Parameters:
- HEADER, 8'hA5, first byte of every frame.
- IDLE_GAP, 0, minimum idle cycles after `done` before the next `start` is accepted (0..15).

Ports:
- clk  input  1  sole clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; captures all value inputs when accepted.
- in_reg8  input  8  unsigned byte field.
- in_reg8_signed  input  8  signed byte field.
- in_reg32  input  32  unsigned word field.
- in_reg32_signed  input  32  signed word field.
- in_int  input  32  signed int field.
- in_longint  input  64  signed longint field.
- in_bits65  input  65  wide bit-vector field.
- data  output  8  current byte.
- valid  output  1  data is valid.
- ready  input  1  sink accepts when valid && ready.
- busy  output  1  frame in progress (snapshot held).
- done  output  1  one-cycle pulse after the checksum byte is accepted.

Behaviour:
- Reset (async assert, sync release): `data`=0, `valid`=0, `busy`=0, `done`=0, state=IDLE, byte index=0, checksum=0, gap counter=0. Asserting `rst` mid-frame aborts the frame immediately; no partial continuation after release.
- `start` is accepted only in IDLE with gap counter==0. The snapshot registers load on that edge. `start` at any other time is ignored and not queued.
- States: IDLE -> HDR -> PAYLOAD -> CSUM -> IDLE.
  - [SEQ sits between HDR and PAYLOAD only with the optional feature.]
  - A transition occurs only on a handshake (valid && ready) of the current byte.
- Frame layout, 33 bytes, each field little-endian (LSB byte first):
  - HEADER
  - reg8 (1 byte)
  - reg8_signed (1)
  - reg32 (4)
  - reg32_signed (4)
  - int (4)
  - longint (8)
  - bits65 (9; byte 8 = {7'b0, bit64})
  - CSUM
- Payload is 31 bytes; byte index runs 0..30 and wraps to 0 on CSUM entry.
- Signed fields are sent as raw two's-complement bit patterns. No sign extension; bits65 padding is always zero.
- CSUM = XOR of all payload bytes (excludes HEADER, and excludes SEQ when present). It accumulates on each payload handshake.
- Latency and handshake:
  - `valid` and the HEADER byte appear on the edge that accepts `start`, i.e. the first cycle after `start` is sampled.
  - Zero-wait sink: one byte per cycle, 33 cycles per frame.
  - While valid && !ready, `data` and `valid` hold stable. `valid` never drops mid-frame.
- `busy`=1 from the start-accept edge until the CSUM handshake edge inclusive.
- `done` pulses in the cycle after the CSUM handshake; `valid` is 0 that cycle.
- Gap counter loads IDLE_GAP on the CSUM handshake and decrements to 0 in IDLE.
  - `start` coinciding with the CSUM handshake is ignored.
  - `start` in the `done` cycle is accepted only if IDLE_GAP==0.
- Input changes after acceptance have no effect on the frame in flight.

Optional Feature:
- TYPED_FRAME_TX_SEQNUM_EN defined:
  - An 8-bit sequence byte is inserted after HEADER; frame is 34 bytes.
  - Sequence counter resets to 0 and increments by 1 (mod 256, 0xFF -> 0x00) on each `done`.
  - The SEQ byte is excluded from CSUM.
- Undefined: no SEQ state or counter; 33-byte frame exactly as above.

Test Plan:
- All inputs 0, ready=1, start pulse -> A5, 31x 00, CSUM 00; valid high exactly 33 consecutive cycles; `done` one cycle later.
- in_reg8=0x01, in_reg8_signed=-1 (0xFF), others 0 -> bytes 1-2 = 01 FF; CSUM=0xFE.
- in_longint=-2, in_bits65=65'h1_0000_0000_0000_0001, others 0 -> longint bytes FE FF FF FF FF FF FF FF; bits65 bytes 01 00x7 01; CSUM=0x01.
- ready toggling 1/0 every cycle, in_reg32=0xDEADBEEF -> data bytes EF BE AD DE unchanged while stalled; frame completes in 65 cycles; no byte duplicated or skipped.
- start held high through a frame plus start on CSUM handshake (IDLE_GAP=0) -> exactly one frame; start in `done` cycle launches the second frame; with IDLE_GAP=3, start is ignored for 3 idle cycles.
- rst asserted at payload byte 10 -> outputs 0 the same cycle; after release, a new start yields a complete fresh frame. With TYPED_FRAME_TX_SEQNUM_EN, SEQ reads 00, 01, 02 on three back-to-back frames.
